// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD best-match decision stage.
package sad_pkg;

  localparam int unsigned SAD_W_DEF = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StDone   = 2'd2
  } sad_state_e;

  // Number of candidate positions in a (2R+1)x(2R+1) search window.
  function automatic int unsigned ncand(input int unsigned r);
    return (2 * r + 1) * (2 * r + 1);
  endfunction

endpackage

// File: rtl/sad_raster_cnt.sv
// Signed (x, y) raster counter over -SearchR..+SearchR in both axes.
// clear_i reloads (-R, -R); adv_i steps x, wrapping into the next row.
module sad_raster_cnt
  import sad_pkg::*;
#(
  parameter int unsigned SearchR = 4,
  parameter int unsigned MvW     = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  adv_i,
  output logic signed [MvW-1:0] x_o,
  output logic signed [MvW-1:0] y_o,
  output logic                  last_o
);

  localparam logic signed [MvW-1:0] MvMax = MvW'(SearchR);
  localparam logic signed [MvW-1:0] MvMin = -MvMax;

  logic signed [MvW-1:0] x_q, x_d, y_q, y_d;

  // Position register with synchronous reset to the window origin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= MvMin;
      y_q <= MvMin;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Next position: clear wins over advance; x wraps at +R and bumps y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = MvMin;
      y_d = MvMin;
    end else if (adv_i) begin
      if (x_q == MvMax) begin
        x_d = MvMin;
        y_d = y_q + MvW'(1);
      end else begin
        x_d = x_q + MvW'(1);
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == MvMax) && (y_q == MvMax);

endmodule

// File: rtl/sad_best_match.sv
// Full-search motion-estimation decision stage: tracks the minimum SAD over a
// raster-ordered search window and reports its motion vector with a done pulse.
// Optional feature macro: SAD_BEST_MATCH_EARLY_TERM_EN (adds early_thresh input
// and stops the search at the first SAD <= early_thresh).
module sad_best_match
  import sad_pkg::*;
#(
  parameter int unsigned SAD_W    = SAD_W_DEF,
  parameter int unsigned SEARCH_R = 4,
  parameter int unsigned MV_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sad_valid,
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
  input  logic [SAD_W-1:0]       early_thresh,
`endif
  input  logic [SAD_W-1:0]       sad_in,
  output logic                   sad_ready,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mv_x,
  output logic signed [MV_W-1:0] best_mv_y,
  output logic [7:0]             cand_idx
);

  localparam logic signed [MV_W-1:0] MvMin = -(MV_W'(SEARCH_R));

  sad_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [SAD_W-1:0]      min_sad_q, min_sad_d, best_sad_q, best_sad_d;
  logic signed [MV_W-1:0] min_x_q, min_x_d, min_y_q, min_y_d;
  logic signed [MV_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
  logic signed [MV_W-1:0] cur_x, cur_y;
  logic                  cur_last, clear, xfer, stop;

  assign clear = (state_q == StIdle) && start;
  assign xfer  = (state_q == StSearch) && sad_valid;

  sad_raster_cnt #(
    .SearchR (SEARCH_R),
    .MvW     (MV_W)
  ) u_raster (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .adv_i   (xfer),
    .x_o     (cur_x),
    .y_o     (cur_y),
    .last_o  (cur_last)
  );

  // State, running minimum and published result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      min_sad_q  <= '1;
      min_x_q    <= '0;
      min_y_q    <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      min_sad_q  <= min_sad_d;
      min_x_q    <= min_x_d;
      min_y_q    <= min_y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
    end
  end

  // FSM next-state, compare/latch and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    min_sad_d  = min_sad_q;
    min_x_d    = min_x_q;
    min_y_d    = min_y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    sad_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    stop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d     = 8'd0;
          min_sad_d = '1;
          min_x_d   = MvMin;
          min_y_d   = MvMin;
          state_d   = StSearch;
        end
      end
      StSearch: begin
        sad_ready = 1'b1;
        busy      = 1'b1;
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          // First transfer loads unconditionally so an all-ones window still has a winner.
          if ((cnt_q == 8'd0) || (sad_in < min_sad_q)) begin
            min_sad_d = sad_in;
            min_x_d   = cur_x;
            min_y_d   = cur_y;
          end
`ifdef SAD_BEST_MATCH_EARLY_TERM_EN
          if (sad_in <= early_thresh) begin
            min_sad_d = sad_in;
            min_x_d   = cur_x;
            min_y_d   = cur_y;
            stop      = 1'b1;
          end
`endif
          if (cur_last || stop) begin
            // Publish on entry to DONE so best_* are valid while done is high.
            best_sad_d = min_sad_d;
            best_x_d   = min_x_d;
            best_y_d   = min_y_d;
            state_d    = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign best_sad  = best_sad_q;
  assign best_mv_x = best_x_q;
  assign best_mv_y = best_y_q;
  assign cand_idx  = cnt_q;

endmodule
